// File: rtl/pmem_line_responder_pkg.sv
// Shared types and constants for the physical-memory line responder.
package pmem_line_responder_pkg;

  localparam int unsigned LineWidth = 128;
  localparam int unsigned AddrWidth = 16;

  typedef logic [11:0] lc3b_line_addr;

  typedef enum logic [1:0] {
    StIdle,
    StRdBurst,
    StWrBurst,
    StResp
  } lc3b_pmem_state;

endpackage

// File: rtl/pmem_line_responder_if.sv
// Line-request side and backing-memory burst side of the responder, bundled as one bus.
interface pmem_line_responder_if #(
  parameter int unsigned BEAT_WIDTH = 64
);
  logic [15:0]           pmem_address;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [127:0]          pmem_wdata;
  logic [127:0]          pmem_rdata;
  logic                  pmem_resp;
  logic [15:0]           mem_address;
  logic                  mem_read;
  logic                  mem_write;
  logic [BEAT_WIDTH-1:0] mem_wdata;
  logic [BEAT_WIDTH-1:0] mem_rdata;
  logic                  mem_beat;

  // Requester plus backing memory.
  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata, mem_rdata, mem_beat,
    input  pmem_rdata, pmem_resp, mem_address, mem_read, mem_write, mem_wdata
  );

  // The responder itself.
  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata, mem_rdata, mem_beat,
    output pmem_rdata, pmem_resp, mem_address, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/pmem_line_responder_line_beat_buffer.sv
// Line assembly/hold register with a beat counter selecting the active slice.
module pmem_line_responder_line_beat_buffer
  import pmem_line_responder_pkg::*;
#(
  parameter int unsigned BEATS      = 2,
  parameter int unsigned BEAT_WIDTH = 64,
  localparam int unsigned CntWidth  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [LineWidth-1:0]  load_line,
  input  logic                  capture,
  input  logic [BEAT_WIDTH-1:0] beat_in,
  input  logic                  cnt_clr,
  input  logic                  cnt_inc,
  output logic [LineWidth-1:0]  line,
  output logic [LineWidth-1:0]  assembled,
  output logic [BEAT_WIDTH-1:0] beat_out,
  output logic                  last
);

  logic [LineWidth-1:0] line_q;
  logic [CntWidth-1:0]  cnt_q;

  // Current line with the incoming beat merged in; lets the last beat complete the line
  // in the same cycle it arrives.
  always_comb begin
    assembled = line_q;
    assembled[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] = beat_in;
  end

  assign line     = line_q;
  assign beat_out = line_q[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH];
  assign last     = (cnt_q == CntWidth'(BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (load) begin
        line_q <= load_line;
      end else if (capture) begin
        line_q <= assembled;
      end
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pmem_line_responder.sv
// Line-to-burst responder with a one-line read buffer kept coherent by write-through.
module pmem_line_responder
  import pmem_line_responder_pkg::*;
#(
  parameter int unsigned BEATS      = 2,
  parameter int unsigned BEAT_WIDTH = 64
) (
  input logic                   clk,
  input logic                   rst_n,
  pmem_line_responder_if.slave  bus
);

  lc3b_pmem_state       state_q;
  lc3b_line_addr        line_addr_q;
  lc3b_line_addr        buf_tag_q;
  logic                 buf_valid_q;
  logic [LineWidth-1:0] buf_data_q;
  logic [LineWidth-1:0] rdata_q;

  logic                 bb_load;
  logic                 bb_capture;
  logic                 bb_cnt_clr;
  logic                 bb_cnt_inc;
  logic [LineWidth-1:0] bb_line;
  logic [LineWidth-1:0] bb_assembled;
  logic [BEAT_WIDTH-1:0] bb_beat_out;
  logic                 bb_last;

  logic                 req_hit;
  logic                 burst_beat;
  logic                 unused_offset;

  assign unused_offset = ^bus.pmem_address[3:0];

  assign req_hit    = buf_valid_q && (buf_tag_q == bus.pmem_address[15:4]);
  assign burst_beat = bus.mem_beat && ((state_q == StRdBurst) || (state_q == StWrBurst));

  always_comb begin
    bb_load    = (state_q == StIdle) && bus.pmem_write;
    bb_capture = (state_q == StRdBurst) && bus.mem_beat;
    bb_cnt_inc = burst_beat;
    bb_cnt_clr = burst_beat && bb_last;
  end

  pmem_line_responder_line_beat_buffer #(
    .BEATS      (BEATS),
    .BEAT_WIDTH (BEAT_WIDTH)
  ) u_beat_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (bb_load),
    .load_line (bus.pmem_wdata),
    .capture   (bb_capture),
    .beat_in   (bus.mem_rdata),
    .cnt_clr   (bb_cnt_clr),
    .cnt_inc   (bb_cnt_inc),
    .line      (bb_line),
    .assembled (bb_assembled),
    .beat_out  (bb_beat_out),
    .last      (bb_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      line_addr_q <= '0;
      buf_tag_q   <= '0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      rdata_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Write takes priority when both requests are raised.
          if (bus.pmem_write) begin
            line_addr_q <= bus.pmem_address[15:4];
            state_q     <= StWrBurst;
          end else if (bus.pmem_read && req_hit) begin
            rdata_q <= buf_data_q;
            state_q <= StResp;
          end else if (bus.pmem_read) begin
            line_addr_q <= bus.pmem_address[15:4];
            state_q     <= StRdBurst;
          end
        end
        StRdBurst: begin
          if (bus.mem_beat && bb_last) begin
            buf_tag_q   <= line_addr_q;
            buf_data_q  <= bb_assembled;
            buf_valid_q <= 1'b1;
            rdata_q     <= bb_assembled;
            state_q     <= StResp;
          end
        end
        StWrBurst: begin
          if (bus.mem_beat && bb_last) begin
            if (buf_valid_q && (buf_tag_q == line_addr_q)) begin
              buf_data_q <= bb_line;
            end
            state_q <= StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.pmem_rdata  = rdata_q;
  assign bus.pmem_resp   = (state_q == StResp);
  assign bus.mem_address = {line_addr_q, 4'h0};
  assign bus.mem_read    = (state_q == StRdBurst);
  assign bus.mem_write   = (state_q == StWrBurst);
  assign bus.mem_wdata   = bb_beat_out;

endmodule
